// File: rtl/sordm5_ddram_arbiter.sv
// sordm5_ddram_arbiter: round-robin byte-to-64-bit DDRAM arbiter for the ioctl writer and CAS reader.
// Define SORDM5_DDRAM_RDCACHE_EN to add a one-line read cache.
module sordm5_ddram_arbiter #(
  parameter logic [28:0] BASE_ADDR = 29'h0600000,
  parameter logic [7:0]  BURST     = 8'd1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        wr_req,
  input  logic [24:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [24:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_ack,
  output logic        busy,
  output logic        DDRAM_CLK,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);
  typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT} state_t;
  state_t state;
  logic last_rd, drop_rd, wr_ok, rd_ok, grant_wr, grant_rd, hit;
  logic [24:0] addr_q;
  logic [7:0] cache_byte;
  assign DDRAM_CLK = clk_sys;
  assign DDRAM_BURSTCNT = BURST;
  assign DDRAM_ADDR = BASE_ADDR + {7'd0, addr_q[24:3]};
  assign busy = state != IDLE || drop_rd;
  // an asserted ack blocks a second grant to the same still-held request
  assign wr_ok = wr_req && !wr_ack && !drop_rd;
  assign rd_ok = rd_req && !rd_ack && !drop_rd;
  assign grant_wr = wr_ok && (!rd_ok || last_rd);
  assign grant_rd = rd_ok && !grant_wr;
`ifdef SORDM5_DDRAM_RDCACHE_EN
  logic [63:0] line;
  logic [21:0] tag;
  logic valid;
  assign hit = valid && tag == rd_addr[24:3];
  assign cache_byte = line[{rd_addr[2:0], 3'b000} +: 8];
  always_ff @(posedge clk_sys)
    if (reset) valid <= 1'b0;
    else if (state == RD_WAIT && DDRAM_DOUT_READY) begin
      line <= DDRAM_DOUT;
      tag <= addr_q[24:3];
      valid <= 1'b1;
    end else if (state == WR_ISSUE && !DDRAM_BUSY && tag == addr_q[24:3])
      line[{addr_q[2:0], 3'b000} +: 8] <= DDRAM_DIN[7:0];
`else
  assign hit = 1'b0;
  assign cache_byte = 8'h00;
`endif
  always_ff @(posedge clk_sys)
    if (reset) begin
      state <= IDLE;
      DDRAM_RD <= 1'b0;
      DDRAM_WE <= 1'b0;
      wr_ack <= 1'b0;
      rd_ack <= 1'b0;
      rd_data <= 8'h00;
      addr_q <= 25'd0;
      DDRAM_BE <= 8'h00;
      DDRAM_DIN <= 64'd0;
      last_rd <= 1'b1;
      // a read already in flight will still return data; swallow it
      drop_rd <= state == RD_WAIT;
    end else begin
      wr_ack <= 1'b0;
      rd_ack <= 1'b0;
      if (drop_rd && DDRAM_DOUT_READY) drop_rd <= 1'b0;
      case (state)
        IDLE:
          if (grant_wr) begin
            addr_q <= wr_addr;
            DDRAM_BE <= 8'd1 << wr_addr[2:0];
            DDRAM_DIN <= {8{wr_data}};
            DDRAM_WE <= 1'b1;
            last_rd <= 1'b0;
            state <= WR_ISSUE;
          end else if (grant_rd) begin
            last_rd <= 1'b1;
            if (hit) begin
              rd_data <= cache_byte;
              rd_ack <= 1'b1;
            end else begin
              addr_q <= rd_addr;
              DDRAM_BE <= 8'd1 << rd_addr[2:0];
              DDRAM_RD <= 1'b1;
              state <= RD_ISSUE;
            end
          end
        WR_ISSUE:
          if (!DDRAM_BUSY) begin
            DDRAM_WE <= 1'b0;
            wr_ack <= 1'b1;
            state <= IDLE;
          end
        RD_ISSUE:
          if (!DDRAM_BUSY) begin
            DDRAM_RD <= 1'b0;
            state <= RD_WAIT;
          end
        RD_WAIT:
          if (DDRAM_DOUT_READY) begin
            rd_data <= DDRAM_DOUT[{addr_q[2:0], 3'b000} +: 8];
            rd_ack <= 1'b1;
            state <= IDLE;
          end
      endcase
    end
endmodule

// File: tb/tb_sordm5_ddram_arbiter.sv
// tb_sordm5_ddram_arbiter: directed self-checking bench for sordm5_ddram_arbiter.
module tb_sordm5_ddram_arbiter;
  logic clk_sys, reset, wr_req, wr_ack, rd_req, rd_ack, busy;
  logic [24:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data, DDRAM_BURSTCNT, DDRAM_BE;
  logic DDRAM_CLK, DDRAM_BUSY, DDRAM_DOUT_READY, DDRAM_RD, DDRAM_WE;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT, DDRAM_DIN;
  int total = 0;
  int bad = 0;

  sordm5_ddram_arbiter dut (
    .clk_sys(clk_sys), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack),
    .busy(busy), .DDRAM_CLK(DDRAM_CLK), .DDRAM_BUSY(DDRAM_BUSY),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task tick;
    @(posedge clk_sys);
    #1;
  endtask

  task test_reset;
    reset = 1'b1;
    {wr_req, rd_req, DDRAM_BUSY, DDRAM_DOUT_READY} = 4'b0;
    wr_addr = 25'd0; rd_addr = 25'd0; wr_data = 8'd0; DDRAM_DOUT = 64'd0;
    tick; tick;
    total++;
    if ({DDRAM_WE, DDRAM_RD, wr_ack, rd_ack, busy} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {DDRAM_WE, DDRAM_RD, wr_ack, rd_ack, busy});
    end
    total++;
    if ({rd_data, DDRAM_ADDR, DDRAM_BE, DDRAM_DIN} !== {8'h00, 29'h0600000, 8'h00, 64'd0}) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h/%h exp=00/0600000/00/0", rd_data, DDRAM_ADDR, DDRAM_BE, DDRAM_DIN);
    end
    total++;
    if (DDRAM_BURSTCNT !== 8'd1) begin
      bad++; $display("FAIL burstcnt got=%h exp=01", DDRAM_BURSTCNT);
    end
    reset = 1'b0;
    tick;
  endtask

  task test_write;
    int n, we_n;
    n = 0; we_n = 0;
    wr_addr = 25'h0000005; wr_data = 8'hA5; wr_req = 1'b1;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      tick;
      if (DDRAM_WE) begin
        we_n++;
        total++;
        if ({DDRAM_ADDR, DDRAM_BE, DDRAM_DIN} !== {29'h0600000, 8'h20, 64'hA5A5A5A5A5A5A5A5}) begin
          bad++; $display("FAIL write_cmd got=%h/%h/%h exp=0600000/20/a5a5a5a5a5a5a5a5", DDRAM_ADDR, DDRAM_BE, DDRAM_DIN);
        end
      end
      if (wr_ack) begin n = i; wr_req = 1'b0; end
    end
    total++;
    if (n != 2) begin bad++; $display("FAIL write_latency got=%0d exp=2", n); end
    total++;
    if (we_n != 1) begin bad++; $display("FAIL write_we_cycles got=%0d exp=1", we_n); end
    tick;
    total++;
    if ({wr_ack, busy} !== 2'b00) begin bad++; $display("FAIL write_ack_pulse got=%b exp=00", {wr_ack, busy}); end
  endtask

  task test_read;
    logic seen;
    seen = 1'b0;
    rd_addr = 25'h000000A; rd_req = 1'b1;
    tick;
    total++;
    if ({DDRAM_RD, DDRAM_ADDR} !== {1'b1, 29'h0600001}) begin
      bad++; $display("FAIL read_cmd got=%b/%h exp=1/0600001", DDRAM_RD, DDRAM_ADDR);
    end
    tick;
    total++;
    if (DDRAM_RD !== 1'b0) begin bad++; $display("FAIL read_accept got=%b exp=0", DDRAM_RD); end
    repeat (4) begin tick; seen |= rd_ack | DDRAM_RD; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL read_wait got=%b exp=0", seen); end
    DDRAM_DOUT = 64'h0807060504030201; DDRAM_DOUT_READY = 1'b1;
    tick;
    DDRAM_DOUT_READY = 1'b0;
    total++;
    if ({rd_ack, rd_data} !== {1'b1, 8'h03}) begin
      bad++; $display("FAIL read_data got=%b/%h exp=1/03", rd_ack, rd_data);
    end
    rd_req = 1'b0;
    tick;
    total++;
    if ({rd_ack, rd_data} !== {1'b0, 8'h03}) begin
      bad++; $display("FAIL read_hold got=%b/%h exp=0/03", rd_ack, rd_data);
    end
  endtask

  task test_contention;
    logic [3:0] ord;
    logic pend, done;
    int g, wa, ra;
    ord = 4'd0; pend = 1'b0; done = 1'b0; g = 0; wa = 0; ra = 0;
    wr_addr = 25'h0000008; wr_data = 8'h5A; rd_addr = 25'h000001F;
    DDRAM_DOUT = 64'hF0E0D0C0B0A09080;
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      tick;
      DDRAM_DOUT_READY = pend;
      pend = 1'b0;
      if (DDRAM_WE) begin ord = {ord[2:0], 1'b1}; g++; end
      if (DDRAM_RD) begin ord = {ord[2:0], 1'b0}; g++; pend = 1'b1; end
      if (wr_ack) wa++;
      if (rd_ack) begin
        ra++;
        if (g >= 4) begin done = 1'b1; rd_req = 1'b0; end
      end
      if (g >= 4) wr_req = 1'b0;
    end
    DDRAM_DOUT_READY = 1'b0;
    total++;
    if (ord !== 4'b1010 || g != 4) begin bad++; $display("FAIL rr_order got=%b/%0d exp=1010/4", ord, g); end
    total++;
    if (wa != 2 || ra != 2) begin bad++; $display("FAIL rr_acks got=%0d/%0d exp=2/2", wa, ra); end
    total++;
    if (rd_data !== 8'hF0) begin bad++; $display("FAIL rr_rdata got=%h exp=f0", rd_data); end
    tick;
  endtask

  task test_backpressure;
    int acc, acks;
    logic stable;
    acc = 0; acks = 0; stable = 1'b1;
    DDRAM_BUSY = 1'b1;
    wr_addr = 25'h1ABCDE3; wr_data = 8'h3C; wr_req = 1'b1;
    tick;
    repeat (10) begin
      if (DDRAM_WE && !DDRAM_BUSY) acc++;
      tick;
      if ({DDRAM_WE, wr_ack, DDRAM_ADDR, DDRAM_BE, DDRAM_DIN} !== {2'b10, 29'h09579BC, 8'h08, 64'h3C3C3C3C3C3C3C3C}) stable = 1'b0;
    end
    total++;
    if (!stable) begin
      bad++; $display("FAIL bp_stable got=%b/%h/%h/%h exp=1/09579bc/08/3c..", DDRAM_WE, DDRAM_ADDR, DDRAM_BE, DDRAM_DIN);
    end
    DDRAM_BUSY = 1'b0;
    repeat (4) begin
      if (DDRAM_WE && !DDRAM_BUSY) acc++;
      tick;
      if (wr_ack) begin acks++; wr_req = 1'b0; end
    end
    total++;
    if (acc != 1 || acks != 1) begin bad++; $display("FAIL bp_accept got=%0d/%0d exp=1/1", acc, acks); end
  endtask

  task test_drop;
    logic seen;
    seen = 1'b0;
    rd_addr = 25'h0000020; rd_req = 1'b1;
    tick; tick;
    reset = 1'b1;
    rd_addr = 25'h0000042;
    tick;
    reset = 1'b0;
    total++;
    if ({busy, DDRAM_RD, rd_data, DDRAM_BE} !== {2'b10, 8'h00, 8'h00}) begin
      bad++; $display("FAIL drop_reset got=%b/%b/%h/%h exp=1/0/00/00", busy, DDRAM_RD, rd_data, DDRAM_BE);
    end
    repeat (5) begin tick; seen |= DDRAM_RD | rd_ack; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL drop_nogrant got=%b exp=0", seen); end
    DDRAM_DOUT = 64'hFFFFFFFFFFFFFFFF; DDRAM_DOUT_READY = 1'b1;
    tick;
    DDRAM_DOUT_READY = 1'b0;
    total++;
    if ({rd_ack, DDRAM_RD, busy} !== 3'b000) begin
      bad++; $display("FAIL drop_stale got=%b exp=000", {rd_ack, DDRAM_RD, busy});
    end
    tick;
    total++;
    if ({DDRAM_RD, DDRAM_ADDR} !== {1'b1, 29'h0600008}) begin
      bad++; $display("FAIL drop_newcmd got=%b/%h exp=1/0600008", DDRAM_RD, DDRAM_ADDR);
    end
    tick;
    DDRAM_DOUT = 64'h1122334455667788; DDRAM_DOUT_READY = 1'b1;
    tick;
    DDRAM_DOUT_READY = 1'b0;
    total++;
    if ({rd_ack, rd_data} !== {1'b1, 8'h66}) begin
      bad++; $display("FAIL drop_newdata got=%b/%h exp=1/66", rd_ack, rd_data);
    end
    rd_req = 1'b0;
    tick;
  endtask

`ifdef SORDM5_DDRAM_RDCACHE_EN
  task test_cache;
    rd_addr = 25'h0000010; rd_req = 1'b1;
    tick;
    total++;
    if (DDRAM_RD !== 1'b1) begin bad++; $display("FAIL cache_miss got=%b exp=1", DDRAM_RD); end
    tick;
    DDRAM_DOUT = 64'h8877665544332211; DDRAM_DOUT_READY = 1'b1;
    tick;
    DDRAM_DOUT_READY = 1'b0;
    total++;
    if ({rd_ack, rd_data} !== {1'b1, 8'h11}) begin bad++; $display("FAIL cache_fill got=%b/%h exp=1/11", rd_ack, rd_data); end
    rd_req = 1'b0;
    tick;
    rd_addr = 25'h0000011; rd_req = 1'b1;
    tick;
    total++;
    if ({rd_ack, DDRAM_RD, rd_data} !== {2'b10, 8'h22}) begin
      bad++; $display("FAIL cache_hit got=%b/%b/%h exp=1/0/22", rd_ack, DDRAM_RD, rd_data);
    end
    rd_req = 1'b0;
    tick;
    wr_addr = 25'h0000011; wr_data = 8'h77; wr_req = 1'b1;
    tick; tick;
    wr_req = 1'b0;
    total++;
    if (wr_ack !== 1'b1) begin bad++; $display("FAIL cache_wr got=%b exp=1", wr_ack); end
    tick;
    rd_req = 1'b1;
    tick;
    total++;
    if ({rd_ack, DDRAM_RD, rd_data} !== {2'b10, 8'h77}) begin
      bad++; $display("FAIL cache_coherent got=%b/%b/%h exp=1/0/77", rd_ack, DDRAM_RD, rd_data);
    end
    rd_req = 1'b0;
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_write;
    test_read;
    test_contention;
    test_backpressure;
    test_drop;
`ifdef SORDM5_DDRAM_RDCACHE_EN
    test_cache;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
